// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: shared types and constants for the MIPS64 fetch stage
package mips_fetch_pkg;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'hFFFF_FFFF_BFC0_0000;
  localparam logic [31:0] INSTR_NOP = 32'h0;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;
  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_e;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO with synchronous flush and combinational head read
module fetch_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem <= '{default: '0};
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) mem[wp] <= din;
      wp <= push ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS64 instruction fetch with credit-limited issue, fetch buffer and redirect drain (optional FETCH_PERF_CNT_EN counters)
module fetch_stage
  import mips_fetch_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter int              INSTR_W  = 32,
  parameter int              DEPTH    = 2,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               id_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_discarded
`endif
);
  localparam int AW = $clog2(DEPTH);
  fetch_state_e state;
  logic live;
  logic [PC_W-1:0] pc, tag;
  logic [AW:0] ifq_count, tq_count, stale, stale_n;
  logic ifq_push, ifq_pop, ifq_full, ifq_empty, tq_full, tq_empty, rsp, req_fire;
  logic [PC_W+INSTR_W-1:0] head;
  assign rsp = imem_rsp_valid && !tq_empty;
  assign req_fire = imem_req_valid && imem_req_ready;
  assign imem_req_valid = live && state == FETCH && !tq_full && !redirect_valid &&
                          ({1'b0, ifq_count} + {1'b0, tq_count}) < (AW+2)'(DEPTH);
  assign imem_req_addr = pc;
  assign ifq_pop = id_valid && id_ready;
  assign ifq_push = rsp && stale == '0 && !redirect_valid && (!ifq_full || ifq_pop);
  assign id_valid = !ifq_empty && !redirect_valid;
  assign {id_pc, id_instr} = head;
  assign stale_n = redirect_valid ? tq_count - (AW+1)'(rsp) : stale - (AW+1)'(rsp && stale != '0);
  fetch_fifo #(.W(PC_W + INSTR_W), .DEPTH(DEPTH)) u_ifq (
    .clk(clk),
    .rst_n(rst_n),
    .flush(redirect_valid),
    .push(ifq_push),
    .pop(ifq_pop),
    .din({tag, imem_rsp_data}),
    .dout(head),
    .count(ifq_count),
    .full(ifq_full),
    .empty(ifq_empty)
  );
  fetch_fifo #(.W(PC_W), .DEPTH(DEPTH)) u_tq (
    .clk(clk),
    .rst_n(rst_n),
    .flush(1'b0),
    .push(req_fire),
    .pop(rsp),
    .din(pc),
    .dout(tag),
    .count(tq_count),
    .full(tq_full),
    .empty(tq_empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      live <= 1'b0;
      pc <= RESET_PC;
      stale <= '0;
      state <= FETCH;
    end else begin
      live <= 1'b1;
      pc <= redirect_valid ? redirect_pc & ~PC_W'(3) : req_fire ? pc + PC_W'(4) : pc;
      stale <= stale_n;
      state <= stale_n != '0 ? DRAIN : FETCH;
    end
`ifdef FETCH_PERF_CNT_EN
  logic [32:0] fetched_sum, discarded_sum;
  assign fetched_sum = {1'b0, perf_fetched} + 33'(ifq_pop);
  assign discarded_sum = {1'b0, perf_discarded} + 33'(rsp && (stale != '0 || redirect_valid)) +
                         (redirect_valid ? 33'(ifq_count) : 33'd0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_discarded <= '0;
    end else begin
      perf_fetched <= fetched_sum[32] ? '1 : fetched_sum[31:0];
      perf_discarded <= discarded_sum[32] ? '1 : discarded_sum[31:0];
    end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage against an in-order variable-latency memory model
module tb_fetch_stage;
  import mips_fetch_pkg::*;
  typedef struct {
    logic [63:0] addr;
    int due;
  } mreq_t;
  localparam logic [63:0] RPC = 64'hFFFF_FFFF_BFC0_0000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, redirect_valid, id_valid, id_ready;
  logic [63:0] imem_req_addr, redirect_pc, id_pc;
  logic [31:0] imem_rsp_data, id_instr;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_discarded;
  logic redir_done;
`endif
  fetch_entry_t sb[$];
  fetch_entry_t e;
  mreq_t mq[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc, lat, ndec, nacc, first_acc, first_idv;
  logic [63:0] exp_pc, s_addr, first_dec_pc;
  logic s_req, s_idv, s_drain;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_valid(id_valid),
    .id_ready(id_ready),
    .id_instr(id_instr),
    .id_pc(id_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_discarded(perf_discarded)
`endif
  );
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step(input logic mrdy, input logic irdy, input logic redir, input logic [63:0] tgt);
    @(negedge clk);
    imem_rsp_valid = mq.size() != 0 && mq[0].due <= cyc;
    imem_rsp_data = imem_rsp_valid ? mem_word(mq[0].addr) : 32'h0;
    imem_req_ready = mrdy;
    id_ready = irdy;
    redirect_valid = redir;
    redirect_pc = tgt;
    #1;
    s_req = imem_req_valid;
    s_addr = imem_req_addr;
    s_idv = id_valid;
    s_drain = dut.state == DRAIN;
    check("no_ifq_overflow", 64'(dut.ifq_push && dut.ifq_full && !dut.ifq_pop), 0);
    if (imem_rsp_valid) void'(mq.pop_front());
    if (s_req && mrdy) begin
      check("req_addr", s_addr, exp_pc);
      mq.push_back('{addr: s_addr, due: cyc + lat});
      sb.push_back('{pc: exp_pc, instr: mem_word(exp_pc)});
      if (first_acc < 0) first_acc = cyc;
      exp_pc += 64'd4;
      nacc++;
    end
    if (s_idv && irdy) begin
      if (first_idv < 0) first_idv = cyc;
      if (ndec == 0) first_dec_pc = id_pc;
      check("sb_nonempty", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_instr", 64'(id_instr), 64'(e.instr));
      end
      ndec++;
    end
    if (redir) begin
      sb.delete();
      exp_pc = tgt & ~64'd3;
    end
    cyc++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    id_ready = 1'b0;
    mq.delete();
    sb.delete();
    #1;
    check("rst_req_valid", 64'(imem_req_valid), 0);
    check("rst_id_valid", 64'(id_valid), 0);
    check("rst_req_addr", imem_req_addr, RPC);
    check("rst_id_instr", 64'(id_instr), 0);
    check("rst_id_pc", id_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = RPC;
    cyc = 0;
    lat = 1;
    ndec = 0;
    nacc = 0;
    first_acc = -1;
    first_idv = -1;
    first_dec_pc = '0;
    step(0, 0, 0, 0);
    cyc = 0;
  endtask
  initial begin
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0);
      if (i == 1) check("t1_back_to_back", nacc, 2);
    end
    check("t1_first_accept", 64'(first_acc), 0);
    check("t1_idv_latency", 64'(first_idv - first_acc), 2);
    check("t1_first_id_pc", first_dec_pc, RPC);
    check("t1_accepted", nacc, 8);
    check("t1_decoded", ndec, 7);
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0);
    check("t2_held_requests", nacc, 2);
    check("t2_req_stalled", 64'(s_req), 0);
    check("t2_resume_addr", s_addr, RPC + 64'd8);
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0);
    check("t2_decoded", 64'(ndec >= 4), 1);
    do_reset();
    lat = 3;
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 64'h1003);
    check("t3_no_req_redirect", 64'(s_req), 0);
    step(1, 1, 0, 0);
    check("t3_drain", 64'(s_drain), 1);
    check("t3_no_req_drain", 64'(s_req), 0);
    step(1, 1, 0, 0);
    check("t3_no_req_drain2", 64'(s_req), 0);
    step(1, 1, 0, 0);
    check("t3_refetch_state", 64'(s_drain), 0);
    check("t3_req_valid", 64'(s_req), 1);
    check("t3_req_addr", s_addr, 64'h1000);
    ndec = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    check("t3_first_id_pc", first_dec_pc, 64'h1000);
    do_reset();
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    step(1, 1, 1, 64'h2000);
    check("t4_buffered", 64'(dut.ifq_count), 1);
    check("t4_idv_redirect", 64'(s_idv), 0);
    step(1, 1, 0, 0);
    check("t4_empty_after", 64'(s_idv), 0);
    check("t4_state", 64'(s_drain), 0);
    check("t4_addr", s_addr, 64'h2000);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
    do_reset();
    step(1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 1, 0, 0);
    check("t5_req_top", 64'(s_req), 1);
    check("t5_addr_top", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1, 1, 0, 0);
    check("t5_req_wrap", 64'(s_req), 1);
    check("t5_addr_wrap", s_addr, 64'h0);
    for (int i = 0; i < 6; i++) step(1, 1, 0, 0);
`ifdef FETCH_PERF_CNT_EN
    do_reset();
    check("perf_rst_fetched", 64'(perf_fetched), 0);
    check("perf_rst_discarded", 64'(perf_discarded), 0);
    for (int i = 0; i < 40 && ndec < 5; i++) step(1, 1, 0, 0);
    redir_done = 1'b0;
    for (int i = 0; i < 20 && !redir_done; i++) begin
      if (sb.size() == 2 && mq.size() == 1) begin
        step(1, 0, 1, 64'h3000);
        redir_done = 1'b1;
      end else step(1, 0, 0, 0);
    end
    check("perf_redirect_reached", 64'(redir_done), 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("perf_fetched", 64'(perf_fetched), 5);
    check("perf_discarded", 64'(perf_discarded), 2);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
